// File: rtl/a_mmul_ctrl_if.sv
// Control/memory-port bundle between the matrix-product sequencer, the A-ROM,
// the X-RAM, the MAC and the result store.
interface a_mmul_ctrl_if #(
  parameter int ROM_AW = 4,
  parameter int X_AW   = 4,
  parameter int R_AW   = 4
) ();
  // Handshake: start is a level request sampled every cycle and accepted only
  // while the sequencer is idle (busy=0); it is never queued. aload_done is a
  // level qualifier examined only before a run begins. done is a one-cycle
  // pulse that ends the busy window. rom_en/x_en, mac_en and res_we are
  // single-cycle strobes; the address or flag outputs that go with them are
  // meaningful only in cycles where the strobe is 1 and read 0 otherwise.
  logic              start;
  logic              aload_done;
  logic              busy;
  logic              done;
  logic              rom_en;
  logic [ROM_AW-1:0] rom_addr;
  logic              x_en;
  logic [X_AW-1:0]   x_addr;
  logic              mac_en;
  logic              mac_clr;
  logic              mac_last;
  logic              res_we;
  logic [R_AW-1:0]   res_addr;

  modport master (
    output start, aload_done,
    input  busy, done, rom_en, rom_addr, x_en, x_addr,
           mac_en, mac_clr, mac_last, res_we, res_addr
  );

  modport slave (
    input  start, aload_done,
    output busy, done, rom_en, rom_addr, x_en, x_addr,
           mac_en, mac_clr, mac_last, res_we, res_addr
  );
endinterface

// File: rtl/a_mmul_ctrl.sv
// Matrix-product sequencer: walks r/c/k over A-ROM and X-RAM in lock-step and
// drives the MAC strobes and result writes, two pipeline stages behind issue.
module a_mmul_ctrl #(
  parameter int ROWS   = 4,
  parameter int K      = 4,
  parameter int COLS   = 4,
  parameter int ROM_AW = 4,
  parameter int X_AW   = 4,
  parameter int R_AW   = 4
) (
  input  logic         clk,
  input  logic         rst,
  a_mmul_ctrl_if.slave bus,
  output logic [2:0]   state_dbg
);

  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CCW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KCW = (K > 1)    ? $clog2(K)    : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOAD = 3'd1,
    S_RUN       = 3'd2,
    S_DRAIN     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [RCW-1:0]  r_q;
  logic [CCW-1:0]  c_q;
  logic [KCW-1:0]  k_q;
  logic            drain_q;
  logic            issue;
  logic            k_first, k_last, c_last, r_last, last_issue;
  logic            mac_en_q, mac_clr_q, mac_last_q, res_we_q;
  logic [R_AW-1:0] res_addr_p, res_addr_q;

  always_comb begin
    k_first    = (k_q == '0);
    k_last     = (k_q == KCW'(K - 1));
    c_last     = (c_q == CCW'(COLS - 1));
    r_last     = (r_q == RCW'(ROWS - 1));
    last_issue = issue && k_last && c_last && r_last;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.start) state_d = bus.aload_done ? S_RUN : S_WAIT_LOAD;
      S_WAIT_LOAD: if (bus.aload_done) state_d = S_RUN;
      S_RUN:       if (last_issue) state_d = S_DRAIN;
      S_DRAIN:     if (drain_q) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: issue-side strobes and addresses are decoded from the state
  always_comb begin
    issue        = (state_q == S_RUN);
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.rom_en   = issue;
    bus.x_en     = issue;
    bus.rom_addr = '0;
    bus.x_addr   = '0;
    if (issue) begin
      bus.rom_addr = ROM_AW'(int'(k_q) * COLS + int'(c_q));
      bus.x_addr   = X_AW'(int'(r_q) * K + int'(k_q));
    end
    bus.mac_en   = mac_en_q;
    bus.mac_clr  = mac_clr_q;
    bus.mac_last = mac_last_q;
    bus.res_we   = res_we_q;
    bus.res_addr = res_addr_q;
    state_dbg    = state_q;
  end

  // Nested r/c/k counters; the final issue wraps all three back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
      if (issue) begin
        k_q <= k_last ? '0 : k_q + 1'b1;
        if (k_last) begin
          c_q <= c_last ? '0 : c_q + 1'b1;
          if (c_last) r_q <= r_last ? '0 : r_q + 1'b1;
        end
      end else begin
        r_q <= '0;
        c_q <= '0;
        k_q <= '0;
      end
    end
  end

  // Stage 1 aligns with memory read data; stage 2 with the registered accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_last_q <= 1'b0;
      res_addr_p <= '0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
    end else begin
      mac_en_q   <= issue;
      mac_clr_q  <= issue && k_first;
      mac_last_q <= issue && k_last;
      res_addr_p <= issue ? R_AW'(int'(r_q) * COLS + int'(c_q)) : '0;
      res_we_q   <= mac_last_q;
      res_addr_q <= mac_last_q ? res_addr_p : '0;
    end
  end

endmodule

// File: doc/a_mmul_ctrl.md
# a_mmul_ctrl

Sequencer for the matrix-product datapath: computes result C = X·A by stepping the coefficient ROM (A, K×COLS, loaded by the A-ROM loader) and the input RAM (X, ROWS×K) in lock-step. It drives the MAC clear, enable and last strobes and the result-memory write port. It sits between the A-ROM top (consumes `aload_done`, drives `rom_addr`) and the MAC/result storage. One `start` produces one complete product, and completion is signalled with a one-cycle `done` pulse.

## Interface
- ROWS, 4, rows of X and C
- K, 4, inner dimension (rows of A, columns of X)
- COLS, 4, columns of A and C
- ROM_AW, 4, A-ROM address width; must hold K*COLS-1
- X_AW, 4, X-RAM address width; must hold ROWS*K-1
- R_AW, 4, result address width; must hold ROWS*COLS-1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low
- start  in  1  request one full product; level sampled per cycle
- aload_done  in  1  A-ROM load complete (level)
- busy  out  1  product in progress
- done  out  1  one-cycle completion pulse
- rom_en  out  1  A-ROM read enable
- rom_addr  out  ROM_AW  A-ROM read address
- x_en  out  1  X-RAM read enable
- x_addr  out  X_AW  X-RAM read address
- mac_en  out  1  MAC accumulate enable (data valid from both memories)
- mac_clr  out  1  with mac_en: load product instead of accumulating
- mac_last  out  1  with mac_en: final term of the current dot product
- res_we  out  1  result write enable
- res_addr  out  R_AW  result write address

## Operation
- States:
  - IDLE: waits for `start`.
  - WAIT_LOAD: `start` accepted, `aload_done` low.
  - RUN: issues reads.
  - DRAIN: 2 cycles, flushes the pipeline.
  - DONE: 1 cycle.
- IDLE transitions on `start`=1:
  - `aload_done`=1: go to RUN.
  - `aload_done`=0: go to WAIT_LOAD.
- WAIT_LOAD goes to RUN on the first cycle `aload_done`=1.
- Issue order in RUN: nested counters r (outer), c, k (inner), one issue per cycle, all starting at 0.
- Each issue drives `rom_addr`=k*COLS+c, `x_addr`=r*K+k and `rom_en`=`x_en`=1.
- The counters wrap k→0 and then c, and c→0 and then r.
- After the issue with r=ROWS-1, c=COLS-1, k=K-1, the block goes to DRAIN. There are exactly ROWS*COLS*K issue cycles.
- DRAIN goes to DONE after 2 cycles. DONE asserts `done` and returns to IDLE.
- `start` outside IDLE is ignored; requests are not queued.
- `aload_done` is only examined in IDLE and WAIT_LOAD; a deassertion during RUN or DRAIN is ignored.
- `busy`=1 in WAIT_LOAD, RUN, DRAIN and DONE.
- Address arithmetic uses parameter constants only. Results are truncated to the port width, and parameter legality guarantees no overflow.
- Reset (async, any state, including mid-RUN):
  - state returns to IDLE, all counters and pipeline registers clear;
  - every output goes to 0;
  - the partial product is abandoned and no `res_we` or `done` follows.

## Timing
- Memories have 1-cycle synchronous read latency.
- Issue at cycle t gives `mac_en`=1 at t+1.
  - `mac_clr`=1 at t+1 iff k=0.
  - `mac_last`=1 at t+1 iff k=K-1.
- `res_we`=1 at t+2 for an issue with k=K-1, with `res_addr`=r*COLS+c.
  - This is one cycle after `mac_last`, once the accumulator is registered.
- Latency with `start` accepted at cycle 0 and `aload_done`=1:
  - `busy` rises at cycle 1;
  - first issue at cycle 1;
  - last issue at cycle N=ROWS*COLS*K;
  - last `mac_en` at N+1, last `res_we` at N+2;
  - `done` at N+3, with `busy` still 1 in that cycle;
  - `busy`=0 from N+4.
  - Defaults give first issue 1, last issue 64, last `res_we` 66, `done` 67.
- `start` held high continuously is re-accepted in the first IDLE cycle (N+4). Minimum start-to-start spacing is N+4 cycles.
- With K=1, `mac_clr` and `mac_last` coincide on every `mac_en`.
- Back-to-back `res_we` pulses occur only when K=1; otherwise consecutive `res_we` pulses are K cycles apart.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, `busy`=0.
- `aload_done`=1, `start` pulse at cycle 0, defaults ->
  - rom_addr/x_addr issue pairs (0,0),(4,1),(8,2),(12,3),(1,0)…;
  - 64 issues, 16 `res_we` at addresses 0..15 in order;
  - `done` at cycle 67 only.
- `start` with `aload_done`=0, raise `aload_done` at cycle 10 -> first issue at cycle 11, `done` at cycle 77.
- `start` pulses during RUN and DRAIN -> ignored; exactly one `done`. `start` held high -> second run begins with first issue at cycle 69.
- Assert `rst` at issue 30 -> outputs 0 immediately. A subsequent `start` gives a full 64-issue run from address 0 with no stale `res_we`.
- Check the `mac_clr`/`mac_last` pairing against a reference model for ROWS=2, K=3, COLS=2 (ROM_AW=3, X_AW=3, R_AW=2) -> 12 issues, 4 `res_we`, `done` at cycle 15.
